fofb_packet_tx: RTL and testbench

Builds cell-link FOFB packets from locally measured BPM samples and drives them onto the outgoing AXI-Stream toward the Aurora TX path. Each packet is one 32-bit header followed by X, Y and S words, in the exact format the FOFB receive/readout stage dissects. A small FIFO absorbs samples that arrive while the link is back-pressured. Samples arriving when the FIFO is full are dropped and counted.

---
 rtl/fofb_packet_tx.sv | 165 ++++++++++++++++
 tb/tb_fofb_packet_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fofb_packet_tx.sv
// FOFB cell-link packet builder: queues BPM samples and streams header/X/Y/S words on AXI-Stream.
// Define FOFB_PACKET_TX_LOSS_FLAG_EN to mark the first S word after a FIFO drop with bit 30.
module fofb_packet_tx #(
  parameter int FOFB_INDEX_WIDTH = 9,
  parameter int CELL_INDEX_WIDTH = 5,
  parameter int FIFO_ADDR_WIDTH  = 4
) (
  input  logic                        auroraClk,
  input  logic                        auroraReset,
  input  logic                        FAstrobe,
  input  logic [CELL_INDEX_WIDTH-1:0] cellIndex,
  input  logic                        fofbEnabled,
  input  logic                        sampleValid,
  input  logic [FOFB_INDEX_WIDTH-1:0] sampleIndex,
  input  logic [31:0]                 sampleX,
  input  logic [31:0]                 sampleY,
  input  logic [31:0]                 sampleS,
  output logic                        TVALID,
  output logic                        TLAST,
  output logic [31:0]                 TDATA,
  input  logic                        TREADY,
  output logic [15:0]                 txCount,
  output logic [15:0]                 dropCount,
  output logic                        fifoEmpty,
  output logic                        fifoFull
);
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int EW    = FOFB_INDEX_WIDTH + 96;
  localparam logic [FIFO_ADDR_WIDTH:0] PTR_ONE = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_X, S_Y, S_S} state_t;
  state_t state, state_nxt;

  logic [EW-1:0]               mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0]    wr_ptr, rd_ptr, wr_base, wr_nxt, rd_nxt;
  logic                        hs, pop, push, drop, more;
  logic [95:0]                 head;
  logic [FOFB_INDEX_WIDTH-1:0] nxt_index;
  logic [31:0]                 hdr_word, s_word, tdata_nxt;
  logic                        tvalid_nxt, tlast_nxt;

  assign fifoEmpty = (wr_ptr == rd_ptr);
  assign fifoFull  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                     (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);

  assign hs     = TVALID && TREADY;
  assign pop    = hs && (state == S_S);
  assign rd_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

  // A flush keeps only the entry whose packet is already on the wire.
  always_comb begin
    wr_base = wr_ptr;
    if (FAstrobe) wr_base = (state == S_IDLE) ? rd_ptr : rd_ptr + PTR_ONE;
  end

  assign push   = sampleValid && (FAstrobe || !fifoFull || pop);
  assign drop   = sampleValid && !push;
  assign wr_nxt = push ? wr_base + PTR_ONE : wr_base;
  assign more   = (wr_base != rd_nxt);

  assign head      = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]][95:0];
  assign nxt_index = mem[rd_nxt[FIFO_ADDR_WIDTH-1:0]][EW-1:96];

  always_comb begin
    hdr_word = 32'hA5BE_0000;
    hdr_word[15] = fofbEnabled;
    hdr_word[10 +: CELL_INDEX_WIDTH] = cellIndex;
    hdr_word[0 +: FOFB_INDEX_WIDTH] = nxt_index;
  end

`ifdef FOFB_PACKET_TX_LOSS_FLAG_EN
  logic lossPending;

  always_ff @(posedge auroraClk or posedge auroraReset) begin
    if (auroraReset)              lossPending <= 1'b0;
    else if (drop)                lossPending <= 1'b1;
    else if (state == S_Y && hs)  lossPending <= 1'b0;
  end

  always_comb begin
    s_word = head[31:0];
    s_word[30] = head[30] | lossPending;
  end
`else
  assign s_word = head[31:0];
`endif

  always_ff @(posedge auroraClk) begin
    if (push) mem[wr_base[FIFO_ADDR_WIDTH-1:0]] <= {sampleIndex, sampleX, sampleY, sampleS};
  end

  always_ff @(posedge auroraClk or posedge auroraReset) begin
    if (auroraReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tdata_nxt  = TDATA;
    tvalid_nxt = TVALID;
    tlast_nxt  = TLAST;
    case (state)
      S_IDLE: if (!fifoEmpty && !FAstrobe) begin
        state_nxt  = S_HDR;
        tdata_nxt  = hdr_word;
        tvalid_nxt = 1'b1;
      end
      S_HDR: if (hs) begin
        state_nxt = S_X;
        tdata_nxt = head[95:64];
      end
      S_X: if (hs) begin
        state_nxt = S_Y;
        tdata_nxt = head[63:32];
      end
      S_Y: if (hs) begin
        state_nxt = S_S;
        tdata_nxt = s_word;
        tlast_nxt = 1'b1;
      end
      S_S: if (hs) begin
        tlast_nxt = 1'b0;
        if (more) begin
          state_nxt = S_HDR;
          tdata_nxt = hdr_word;
        end else begin
          state_nxt  = S_IDLE;
          tvalid_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge auroraClk or posedge auroraReset) begin
    if (auroraReset) begin
      state  <= S_IDLE;
      TDATA  <= '0;
      TVALID <= 1'b0;
      TLAST  <= 1'b0;
    end else begin
      state  <= state_nxt;
      TDATA  <= tdata_nxt;
      TVALID <= tvalid_nxt;
      TLAST  <= tlast_nxt;
    end
  end

  // FAstrobe clear wins over a same-cycle packet completion.
  always_ff @(posedge auroraClk or posedge auroraReset) begin
    if (auroraReset) begin
      txCount   <= '0;
      dropCount <= '0;
    end else begin
      if (FAstrobe)                          txCount <= '0;
      else if (pop && txCount != 16'hFFFF)   txCount <= txCount + 16'd1;
      if (drop && dropCount != 16'hFFFF)     dropCount <= dropCount + 16'd1;
    end
  end
endmodule

// File: tb/tb_fofb_packet_tx.sv
// Scoreboard bench for fofb_packet_tx: a queue-level model predicts every packet word and status output.
module tb_fofb_packet_tx;
  logic        auroraClk = 1'b0;
  logic        auroraReset, FAstrobe, fofbEnabled, sampleValid, TREADY;
  logic        TVALID, TLAST, fifoEmpty, fifoFull;
  logic [4:0]  cellIndex;
  logic [8:0]  sampleIndex;
  logic [31:0] sampleX, sampleY, sampleS, TDATA;
  logic [15:0] txCount, dropCount;

  typedef struct { logic [8:0] idx; logic [31:0] x, y, s; } smp_t;
  smp_t        mq[$];
  smp_t        e, h, first_smp;
  int          checks = 0, errors = 0, pos = 0, pkts = 0, vld_cnt = 0, rise_cnt = 0;
  logic [15:0] tx_m = 0, drop_m = 0;
  bit          loss_m = 0, s_flag = 0, held = 0, prev_vld = 0, s_cap_en = 0;
  logic [31:0] held_dat, expw, cap_s;

  fofb_packet_tx dut (
    .auroraClk(auroraClk), .auroraReset(auroraReset), .FAstrobe(FAstrobe),
    .cellIndex(cellIndex), .fofbEnabled(fofbEnabled), .sampleValid(sampleValid),
    .sampleIndex(sampleIndex), .sampleX(sampleX), .sampleY(sampleY), .sampleS(sampleS),
    .TVALID(TVALID), .TLAST(TLAST), .TDATA(TDATA), .TREADY(TREADY),
    .txCount(txCount), .dropCount(dropCount), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull)
  );

  always #5 auroraClk = ~auroraClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [8:0] idx);
    return 32'hA5BE0000 | (32'(fofbEnabled) << 15) | (32'(cellIndex) << 10) | 32'(idx);
  endfunction

  // Model of the edge that follows each falling edge: flush, then pop, then write.
  always @(negedge auroraClk) begin
    if (auroraReset) begin
      mq.delete(); pos = 0; tx_m = 0; drop_m = 0; loss_m = 0; s_flag = 0; held = 0; prev_vld = 0;
    end else begin
      chk("txCount", 32'(txCount), 32'(tx_m));
      chk("dropCount", 32'(dropCount), 32'(drop_m));
      chk("fifoEmpty", 32'(fifoEmpty), 32'(mq.size() == 0));
      chk("fifoFull", 32'(fifoFull), 32'(mq.size() == 16));
      if (held) begin
        chk("stall_hold_valid", 32'(TVALID), 1);
        chk("stall_hold_data", TDATA, held_dat);
      end
      if (pos != 0) chk("tvalid_mid_packet", 32'(TVALID), 1);
      held = TVALID && !TREADY;
      held_dat = TDATA;
      if (TVALID) vld_cnt++;
      if (TVALID && !prev_vld) rise_cnt++;
      prev_vld = TVALID;

      if (FAstrobe) begin
        if (TVALID && mq.size() > 0) begin
          h = mq[0]; mq.delete(); mq.push_back(h);
        end else mq.delete();
        tx_m = 0;
      end

      if (TVALID && TREADY) begin
        if (mq.size() == 0) chk("unexpected_word", mq.size(), 1);
        else begin
          e = mq[0];
          case (pos)
            0: expw = hdr(e.idx);
            1: expw = e.x;
            2: expw = e.y;
            default: expw = e.s | (s_flag ? 32'h4000_0000 : 32'h0);
          endcase
          chk($sformatf("word%0d", pos), TDATA, expw);
          chk("tlast", 32'(TLAST), 32'(pos == 3));
`ifdef FOFB_PACKET_TX_LOSS_FLAG_EN
          if (pos == 2) begin s_flag = loss_m; loss_m = 0; end
`endif
          if (pos == 3) begin
            if (s_cap_en) begin cap_s = TDATA; s_cap_en = 0; end
            void'(mq.pop_front());
            pkts++;
            if (!FAstrobe && tx_m != 16'hFFFF) tx_m++;
          end
          pos = (pos + 1) % 4;
        end
      end

      if (sampleValid) begin
        if (mq.size() < 16) mq.push_back('{sampleIndex, sampleX, sampleY, sampleS});
        else begin
          if (drop_m != 16'hFFFF) drop_m++;
          loss_m = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge auroraClk); #1;
  endtask

  task automatic send(input logic [8:0] i, input logic [31:0] x, input logic [31:0] y, input logic [31:0] s);
    sampleValid = 1; sampleIndex = i; sampleX = x; sampleY = y; sampleS = s;
    step();
    sampleValid = 0;
  endtask

  task automatic send_rand();
    send(9'($urandom_range(0, 511)), $urandom, $urandom, $urandom);
  endtask

  task automatic fa_pulse();
    FAstrobe = 1; step(); FAstrobe = 0;
  endtask

  task automatic drain(input int budget);
    TREADY = 1;
    for (int i = 0; i < budget && (mq.size() != 0 || TVALID); i++) step();
    chk("drain_done", 32'((mq.size() != 0) || TVALID), 0);
  endtask

  initial begin
    bit found;
    auroraReset = 1; FAstrobe = 0; fofbEnabled = 1; cellIndex = 5'd7; sampleValid = 0;
    sampleIndex = 0; sampleX = 0; sampleY = 0; sampleS = 0; TREADY = 1;
    #12;
    chk("rst_tvalid", 32'(TVALID), 0);
    chk("rst_tlast", 32'(TLAST), 0);
    chk("rst_tdata", TDATA, 0);
    chk("rst_txcount", 32'(txCount), 0);
    chk("rst_dropcount", 32'(dropCount), 0);
    chk("rst_empty", 32'(fifoEmpty), 1);
    chk("rst_full", 32'(fifoFull), 0);
    step(); auroraReset = 0; step();

    // single packet and latency
    send(9'h012, 32'd1, 32'd2, 32'd3);
    chk("lat_n1_tvalid", 32'(TVALID), 0);
    step();
    chk("lat_n2_tvalid", 32'(TVALID), 1);
    chk("first_header", TDATA, 32'hA5BE9C12);
    drain(50);
    chk("t1_txcount", 32'(txCount), 1);

    // back-to-back packets without bubbles
    fa_pulse();
    vld_cnt = 0; rise_cnt = 0;
    repeat (3) send_rand();
    drain(60);
    chk("b2b_valid_cycles", vld_cnt, 12);
    chk("b2b_valid_rises", rise_cnt, 1);
    chk("b2b_txcount", 32'(txCount), 3);

    // TREADY toggling every cycle
    fa_pulse();
    TREADY = 0;
    send_rand();
    for (int i = 0; i < 16; i++) begin TREADY = ~TREADY; step(); end
    drain(40);
    chk("toggle_txcount", 32'(txCount), 1);

    // overflow with the link stalled
    fa_pulse();
    TREADY = 0;
    send(9'h1A5, $urandom, $urandom, 32'h1234_5678);
    first_smp = '{9'h1A5, 32'h0, 32'h0, 32'h1234_5678};
    repeat (17) send_rand();
    step();
    chk("ovf_dropcount", 32'(dropCount), 2);
    chk("ovf_full", 32'(fifoFull), 1);
    s_cap_en = 1;
    drain(200);
`ifdef FOFB_PACKET_TX_LOSS_FLAG_EN
    chk("ovf_first_s", cap_s, first_smp.s | 32'h4000_0000);
`else
    chk("ovf_first_s", cap_s, first_smp.s);
`endif
    chk("ovf_txcount", 32'(txCount), 16);

    // FAstrobe while the X word of packet 1 is on the bus
    fa_pulse();
    TREADY = 0;
    repeat (4) send_rand();
    TREADY = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (TVALID && pos == 1) found = 1;
      else step();
    end
    chk("fa_at_x_word", 32'(found), 1);
    fa_pulse();
    drain(40);
    chk("fa_txcount", 32'(txCount), 1);
    chk("fa_empty", 32'(fifoEmpty), 1);

    // asynchronous reset at the Y word
    send_rand();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (TVALID && pos == 2) found = 1;
      else step();
    end
    chk("rst_at_y_word", 32'(found), 1);
    #2 auroraReset = 1;
    #1;
    chk("midrst_tvalid", 32'(TVALID), 0);
    chk("midrst_txcount", 32'(txCount), 0);
    chk("midrst_dropcount", 32'(dropCount), 0);
    chk("midrst_empty", 32'(fifoEmpty), 1);
    step(); step();
    auroraReset = 0;
    step();
    send_rand();
    drain(40);
    chk("postrst_txcount", 32'(txCount), 1);

    // randomized traffic with stall phases and occasional FAstrobe
    fofbEnabled = 0; cellIndex = 5'h15;
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 400; c++) begin
        sampleValid = ($urandom % 3 == 0);
        sampleIndex = 9'($urandom_range(0, 511));
        sampleX = $urandom; sampleY = $urandom; sampleS = $urandom;
        TREADY = (($urandom % 8) < ((ph % 2 == 1) ? 2 : 7));
        FAstrobe = ($urandom % 150 == 0);
        step();
      end
    end
    sampleValid = 0; FAstrobe = 0;
    drain(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
